// File: rtl/ahb_pkg.sv
// Shared AHB encodings and fill-buffer state type for the I-cache refill path.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        FB_IDLE,
        FB_FILL,
        FB_FULL
    } fb_state_e;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic is_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/line_fill_buffer_if.sv
// Snooped AHB read bus plus critical-word and line-fill outputs of the fill buffer.
interface line_fill_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4
);
    logic [1:0]              htrans;
    logic [ADDR_W-1:0]       read_addr;
    logic                    hready;
    logic [DATA_W-1:0]       read_data;
    logic                    buf_busy;
    logic                    cw_valid;
    logic [ADDR_W-1:0]       cw_addr;
    logic [DATA_W-1:0]       cw_data;
    logic                    fill_valid;
    logic                    fill_ready;
    logic [ADDR_W-1:0]       fill_addr;
    logic [WORDS*DATA_W-1:0] fill_data;
    logic                    err;

    modport master (
        output htrans, read_addr, hready, read_data, fill_ready,
        input  buf_busy, cw_valid, cw_addr, cw_data, fill_valid, fill_addr, fill_data, err
    );

    modport slave (
        input  htrans, read_addr, hready, read_data, fill_ready,
        output buf_busy, cw_valid, cw_addr, cw_data, fill_valid, fill_addr, fill_data, err
    );
endinterface

// File: rtl/ahb_dphase_tracker.sv
// Registers the AHB address phase and flags the edge on which its data phase completes.
module ahb_dphase_tracker
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        htrans_i,
    input  logic [ADDR_W-1:0] read_addr_i,
    input  logic              hready_i,
    input  logic [DATA_W-1:0] read_data_i,
    output logic              beat_valid_o,
    output logic              beat_nonseq_o,
    output logic [ADDR_W-1:0] beat_addr_o,
    output logic [DATA_W-1:0] beat_data_o
);

    logic              ap_valid_q;
    logic              ap_nonseq_q;
    logic [ADDR_W-1:0] ap_addr_q;

    // A stalled data phase (hready low) keeps the pending address phase in place.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ap_valid_q  <= 1'b0;
            ap_nonseq_q <= 1'b0;
            ap_addr_q   <= '0;
        end else if (hready_i) begin
            ap_valid_q  <= is_active(htrans_i);
            ap_nonseq_q <= (htrans_i == HTRANS_NONSEQ);
            ap_addr_q   <= read_addr_i;
        end
    end

    assign beat_valid_o  = hready_i & ap_valid_q;
    assign beat_nonseq_o = ap_nonseq_q;
    assign beat_addr_o   = ap_addr_q;
    assign beat_data_o   = read_data_i;

endmodule

// File: rtl/line_fill_buffer.sv
// Assembles one wrapping refill burst into a cache line, forwarding the critical word
// early and holding the finished line until the cache array takes it.
module line_fill_buffer
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    line_fill_buffer_if.slave bus
);

    localparam int OFF = $clog2(DATA_W / 8);
    localparam int IDX = $clog2(WORDS);
    localparam int LOW = OFF + IDX;

    logic              beat_valid;
    logic              beat_nonseq;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] beat_data;

    ahb_dphase_tracker #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_tracker (
        .clk          (clk),
        .rstn         (rstn),
        .htrans_i     (bus.htrans),
        .read_addr_i  (bus.read_addr),
        .hready_i     (bus.hready),
        .read_data_i  (bus.read_data),
        .beat_valid_o (beat_valid),
        .beat_nonseq_o(beat_nonseq),
        .beat_addr_o  (beat_addr),
        .beat_data_o  (beat_data)
    );

    fb_state_e                    state_q;
    logic [WORDS-1:0]             mask_q;
    logic [ADDR_W-1:0]            base_q;
    logic [WORDS-1:0][DATA_W-1:0] line_q;
    logic                         cw_valid_q;
    logic [ADDR_W-1:0]            cw_addr_q;
    logic [DATA_W-1:0]            cw_data_q;
    logic                         fill_valid_q;
    logic                         buf_busy_q;
    logic                         err_q;

    logic [IDX-1:0]               beat_idx;
    logic [ADDR_W-1:0]            beat_base;
    logic [WORDS-1:0]             beat_onehot;
    logic [WORDS-1:0]             mask_d;
    logic [WORDS-1:0][DATA_W-1:0] fresh_line_d;
    logic                         handshake;
    logic                         start_beat;
    logic                         write_beat;
    logic                         drop_beat;

    // A handshake edge behaves like IDLE for any beat landing on it, so back-to-back lines lose no cycle.
    always_comb begin
        beat_idx                 = beat_addr[OFF +: IDX];
        beat_base                = {beat_addr[ADDR_W-1:LOW], {LOW{1'b0}}};
        beat_onehot              = '0;
        beat_onehot[beat_idx]    = 1'b1;
        mask_d                   = mask_q | beat_onehot;
        fresh_line_d             = '0;
        fresh_line_d[beat_idx]   = beat_data;
        handshake                = (state_q == FB_FULL) && bus.fill_ready;
        start_beat               = beat_valid && beat_nonseq &&
                                   ((state_q != FB_FULL) || handshake);
        write_beat               = beat_valid && !beat_nonseq &&
                                   (state_q == FB_FILL) && (beat_base == base_q);
        drop_beat                = beat_valid && !start_beat && !write_beat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= FB_IDLE;
            mask_q       <= '0;
            base_q       <= '0;
            line_q       <= '0;
            cw_valid_q   <= 1'b0;
            cw_addr_q    <= '0;
            cw_data_q    <= '0;
            fill_valid_q <= 1'b0;
            buf_busy_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cw_valid_q <= 1'b0;
            if (drop_beat) begin
                err_q <= 1'b1;
            end
            if (start_beat) begin
                state_q      <= FB_FILL;
                base_q       <= beat_base;
                mask_q       <= beat_onehot;
                line_q       <= fresh_line_d;
                cw_valid_q   <= 1'b1;
                cw_addr_q    <= beat_addr;
                cw_data_q    <= beat_data;
                fill_valid_q <= 1'b0;
                buf_busy_q   <= 1'b0;
            end else if (write_beat) begin
                mask_q           <= mask_d;
                line_q[beat_idx] <= beat_data;
                if (&mask_d) begin
                    state_q      <= FB_FULL;
                    fill_valid_q <= 1'b1;
                    buf_busy_q   <= 1'b1;
                end
            end else if (handshake) begin
                state_q      <= FB_IDLE;
                mask_q       <= '0;
                fill_valid_q <= 1'b0;
                buf_busy_q   <= 1'b0;
            end
        end
    end

    assign bus.buf_busy   = buf_busy_q;
    assign bus.cw_valid   = cw_valid_q;
    assign bus.cw_addr    = cw_addr_q;
    assign bus.cw_data    = cw_data_q;
    assign bus.fill_valid = fill_valid_q;
    assign bus.fill_addr  = base_q;
    assign bus.fill_data  = line_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Randomized and directed bench for line_fill_buffer against a transaction-level line model.
module tb_line_fill_buffer;
    import ahb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WORDS  = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    line_fill_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) bus ();

    line_fill_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    int testsRun    = 0;
    int testsFailed = 0;
    int cwSeen      = 0;

    // Reference model: pending address phase plus the line being collected as a word array.
    bit          mApValid, mApNonseq, mFilling, mFull, mErr, mCwValid;
    logic [31:0] mApAddr, mBase, mCwAddr, mCwData;
    logic [31:0] mWords[WORDS];
    bit          mHave[WORDS];

    logic [31:0] bData[WORDS];
    logic [31:0] carryData;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mApValid = 0; mApNonseq = 0; mApAddr = '0;
        mFilling = 0; mFull = 0; mErr = 0; mCwValid = 0;
        mBase = '0; mCwAddr = '0; mCwData = '0;
        for (int j = 0; j < WORDS; j++) begin
            mWords[j] = '0;
            mHave[j]  = 0;
        end
    endtask

    task automatic modelStep();
        bit          beat;
        logic [31:0] a;
        int          i, n;
        beat     = bus.hready && mApValid;
        a        = mApAddr;
        i        = int'(a[3:2]);
        mCwValid = 0;
        if (mFull && bus.fill_ready) begin
            mFull = 0;
            for (int j = 0; j < WORDS; j++) mHave[j] = 0;
        end
        if (beat) begin
            if (mFull) begin
                mErr = 1;
            end else if (mApNonseq) begin
                for (int j = 0; j < WORDS; j++) begin
                    mWords[j] = '0;
                    mHave[j]  = 0;
                end
                mBase     = a & ~32'hF;
                mWords[i] = bus.read_data;
                mHave[i]  = 1;
                mFilling  = 1;
                mCwValid  = 1;
                mCwAddr   = a;
                mCwData   = bus.read_data;
            end else if (mFilling && ((a & ~32'hF) == mBase)) begin
                mWords[i] = bus.read_data;
                mHave[i]  = 1;
                n = 0;
                for (int j = 0; j < WORDS; j++) if (mHave[j]) n++;
                if (n == WORDS) begin
                    mFull    = 1;
                    mFilling = 0;
                end
            end else begin
                mErr = 1;
            end
        end
        if (bus.hready) begin
            mApValid  = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);
            mApNonseq = (bus.htrans == HTRANS_NONSEQ);
            mApAddr   = bus.read_addr;
        end
    endtask

    task automatic compareAll();
        logic [127:0] expLine;
        for (int j = 0; j < WORDS; j++) expLine[j*32 +: 32] = mWords[j];
        checkOutput("fill_valid", bus.fill_valid, mFull);
        checkOutput("buf_busy", bus.buf_busy, mFull);
        checkOutput("cw_valid", bus.cw_valid, mCwValid);
        checkOutput("cw_addr", bus.cw_addr, mCwAddr);
        checkOutput("cw_data", bus.cw_data, mCwData);
        checkOutput("fill_addr", bus.fill_addr, mBase);
        checkOutput("fill_data", bus.fill_data, expLine);
        checkOutput("err", bus.err, mErr);
        if (bus.cw_valid === 1'b1) cwSeen++;
    endtask

    task automatic applyStimulus(input logic [1:0] ht, input logic [31:0] addr, input bit rdy,
                                 input logic [31:0] data, input bit fr);
        bus.htrans     = ht;
        bus.read_addr  = addr;
        bus.hready     = rdy;
        bus.read_data  = data;
        bus.fill_ready = fr;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    // Wrapping burst from a0; data of beat k rides in the following cycle's data phase.
    task automatic runBurst(input logic [31:0] a0, input int beats, input int waits,
                            input int frStart, input bit tail);
        logic [31:0] base, addr, d;
        logic [1:0]  ht;
        int          i0, nw;
        base = a0 & ~32'hF;
        i0   = int'(a0[3:2]);
        for (int k = 0; k < beats; k++) begin
            addr = base | 32'(((i0 + k) % WORDS) << 2);
            ht   = (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            d    = (k == 0) ? carryData : bData[k-1];
            nw   = (waits < 0) ? int'($urandom_range(2, 0)) : waits;
            for (int w = 0; w < nw; w++) applyStimulus(ht, addr, 1'b0, $urandom, k >= frStart);
            applyStimulus(ht, addr, 1'b1, d, k >= frStart);
        end
        if (tail) begin
            nw = (waits < 0) ? int'($urandom_range(2, 0)) : waits;
            for (int w = 0; w < nw; w++) applyStimulus(HTRANS_IDLE, '0, 1'b0, $urandom, beats >= frStart);
            applyStimulus(HTRANS_IDLE, '0, 1'b1, bData[beats-1], beats >= frStart);
            carryData = '0;
        end else begin
            carryData = bData[beats-1];
        end
    endtask

    task automatic drain();
        applyStimulus(HTRANS_IDLE, '0, 1'b1, $urandom, 1'b1);
    endtask

    task automatic randomData();
        for (int j = 0; j < WORDS; j++) bData[j] = $urandom;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic doReset();
        #2 rstn = 1'b0;
        #1;
        checkOutput("rst_cw_valid", bus.cw_valid, 0);
        checkOutput("rst_fill_valid", bus.fill_valid, 0);
        checkOutput("rst_buf_busy", bus.buf_busy, 0);
        checkOutput("rst_err", bus.err, 0);
        checkOutput("rst_cw_addr", bus.cw_addr, 0);
        checkOutput("rst_cw_data", bus.cw_data, 0);
        checkOutput("rst_fill_addr", bus.fill_addr, 0);
        checkOutput("rst_fill_data", bus.fill_data, 0);
        modelReset();
        carryData = '0;
        bus.htrans = HTRANS_IDLE; bus.hready = 1'b1; bus.fill_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.htrans = HTRANS_IDLE; bus.read_addr = '0; bus.hready = 1'b1;
        bus.read_data = '0; bus.fill_ready = 1'b0;
        carryData = '0;
        modelReset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        compareAll();

        bData[0] = 32'hAAAA_0001; bData[1] = 32'hBBBB_0002;
        bData[2] = 32'hCCCC_0003; bData[3] = 32'hDDDD_0004;
        cwSeen = 0;
        runBurst(32'h1008, 4, 0, 99, 1);
        checkOutput("wrap4_cw_count", cwSeen, 1);
        checkOutput("wrap4_cw_addr", bus.cw_addr, 32'h1008);
        checkOutput("wrap4_cw_data", bus.cw_data, 32'hAAAA_0001);
        checkOutput("wrap4_fill_valid", bus.fill_valid, 1);
        checkOutput("wrap4_buf_busy", bus.buf_busy, 1);
        checkOutput("wrap4_fill_addr", bus.fill_addr, 32'h1000);
        checkOutput("wrap4_fill_data", bus.fill_data,
                    128'hBBBB_0002_AAAA_0001_DDDD_0004_CCCC_0003);
        drain();
        checkOutput("wrap4_released", bus.fill_valid, 0);

        randomData();
        runBurst(32'h1008, 4, 2, 99, 1);
        drain();

        cwSeen = 0;
        randomData();
        runBurst(32'h2000, 2, 0, 99, 0);
        randomData();
        runBurst(32'h3004, 4, 0, 99, 1);
        checkOutput("abort_cw_count", cwSeen, 2);
        checkOutput("abort_fill_addr", bus.fill_addr, 32'h3000);
        checkOutput("abort_cw_addr", bus.cw_addr, 32'h3004);
        checkOutput("abort_err", bus.err, 0);
        drain();

        randomData();
        runBurst(32'h1000, 4, 0, 99, 1);
        randomData();
        runBurst(32'h2008, 4, 0, 1, 1);
        checkOutput("b2b_err", bus.err, 0);
        checkOutput("b2b_fill_addr", bus.fill_addr, 32'h2000);
        checkOutput("b2b_fill_valid", bus.fill_valid, 1);
        drain();

        doReset();
        cwSeen = 0;
        applyStimulus(HTRANS_SEQ, 32'h0100, 1'b1, $urandom, 1'b0);
        applyStimulus(HTRANS_IDLE, '0, 1'b1, $urandom, 1'b0);
        checkOutput("orphan_err", bus.err, 1);
        checkOutput("orphan_cw_count", cwSeen, 0);
        checkOutput("orphan_fill_valid", bus.fill_valid, 0);

        doReset();
        applyStimulus(HTRANS_NONSEQ, 32'h4000, 1'b1, $urandom, 1'b0);
        applyStimulus(HTRANS_SEQ, 32'h5000, 1'b1, 32'h1234_5678, 1'b0);
        applyStimulus(HTRANS_IDLE, '0, 1'b1, 32'h9ABC_DEF0, 1'b0);
        checkOutput("mismatch_err", bus.err, 1);
        checkOutput("mismatch_fill_valid", bus.fill_valid, 0);

        doReset();
        bData[0] = 32'h1111_1111; bData[1] = 32'h2222_2222;
        bData[2] = 32'h3333_3333; bData[3] = 32'h4444_4444;
        runBurst(32'h6000, 4, 0, 99, 1);
        applyStimulus(HTRANS_NONSEQ, 32'h7000, 1'b1, $urandom, 1'b0);
        applyStimulus(HTRANS_IDLE, '0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("full_beat_err", bus.err, 1);
        checkOutput("full_beat_valid", bus.fill_valid, 1);
        checkOutput("full_beat_data", bus.fill_data,
                    128'h4444_4444_3333_3333_2222_2222_1111_1111);
        drain();

        doReset();
        randomData();
        runBurst(32'h8004, 2, 0, 99, 1);
        doReset();
        randomData();
        runBurst(32'h9000, 4, -1, 99, 1);
        checkOutput("post_rst_fill_addr", bus.fill_addr, 32'h9000);
        checkOutput("post_rst_err", bus.err, 0);
        drain();

        for (int it = 0; it < 80; it++) begin
            int          r, fs;
            logic [31:0] a;
            r  = int'($urandom_range(9, 0));
            a  = $urandom & ~32'h3;
            fs = int'($urandom_range(5, 0));
            if (fs == 5) fs = 99;
            randomData();
            if (r <= 5) begin
                runBurst(a, 4, -1, fs, 1'($urandom_range(1, 0)));
            end else if (r == 6) begin
                runBurst(a, int'($urandom_range(3, 1)), -1, fs, 1'b0);
            end else if (r == 7) begin
                applyStimulus(HTRANS_SEQ, a, 1'b1, $urandom, 1'($urandom_range(1, 0)));
            end else if (r == 8) begin
                applyStimulus({1'b0, 1'($urandom_range(1, 0))}, $urandom, 1'($urandom_range(1, 0)),
                              $urandom, 1'($urandom_range(1, 0)));
            end else if ($urandom_range(3, 0) == 0) begin
                doReset();
            end else begin
                drain();
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
